// File: rtl/ssdec_pkg.sv
// Shared types and the hex segment font for the seven-segment scan driver.
package ssdec_pkg;

    typedef logic [6:0] seg_t;

    typedef enum logic [0:0] {IDLE, SCAN} scan_state_e;

    // Segment order {g,f,e,d,c,b,a}, active-high
    localparam seg_t SEG_FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic seg_t font_lookup(input logic [3:0] nibble);
        return SEG_FONT[nibble];
    endfunction

endpackage

// File: rtl/ssdec_font.sv
// Combinational hex nibble to segment pattern, with forced blank.
module ssdec_font
    import ssdec_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output seg_t       seg_o
);

    always_comb begin
        seg_o = font_lookup(nibble_i);
        if (blank_i) begin
            seg_o = '0;
        end
    end

endmodule

// File: rtl/ssdec_scan.sv
// Time-multiplexed N-digit seven-segment driver with double-buffered frame commit,
// leading-zero blanking, anti-ghost blank window and selectable output polarity.
module ssdec_scan
    import ssdec_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned BLANK_CYC  = 2,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    blank_lz_i,
    output logic [6:0]              seg_out_o,
    output logic                    dp_out_o,
    output logic [NUM_DIGITS-1:0]   digit_sel_o,
    output logic                    frame_done_o
);

    localparam int unsigned PrescW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PrescW-1:0] PrescMax = PrescW'(SCAN_DIV - 1);
    localparam logic [PrescW-1:0] BlankEnd = PrescW'(BLANK_CYC);
    localparam logic [IdxW-1:0]   IdxMax   = IdxW'(NUM_DIGITS - 1);

    scan_state_e             state_q, state_d;
    logic [PrescW-1:0]       presc_q, presc_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic                    wrap_q, wrap_d;
    logic                    commit;

    logic [4*NUM_DIGITS-1:0] pend_value_q, pend_value_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pend_lz_q, pend_lz_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [4*NUM_DIGITS-1:0] act_value_q, act_value_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic                    act_lz_q, act_lz_d;

    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic                    frame_done_q, frame_done_d;

    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [NUM_DIGITS-1:0]   onehot;
    logic [3:0]              cur_nibble;
    logic                    cur_blank;
    logic                    cur_dp;
    seg_t                    font_seg;

    // Scan sequencing: prescaler, digit index and frame-boundary detection
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        idx_d   = idx_q;
        wrap_d  = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                presc_d = '0;
                idx_d   = '0;
                if (enable_i) begin
                    state_d = SCAN;
                    commit  = 1'b1;
                end
            end
            SCAN: begin
                if (!enable_i) begin
                    state_d = IDLE;
                    presc_d = '0;
                    idx_d   = '0;
                end else if (presc_q == PrescMax) begin
                    presc_d = '0;
                    if (idx_q == IdxMax) begin
                        idx_d  = '0;
                        wrap_d = 1'b1;
                        commit = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Double buffer; a load on the commit cycle goes straight through to active
    always_comb begin
        pend_value_d = pend_value_q;
        pend_dp_d    = pend_dp_q;
        pend_lz_d    = pend_lz_q;
        pend_valid_d = pend_valid_q;
        act_value_d  = act_value_q;
        act_dp_d     = act_dp_q;
        act_lz_d     = act_lz_q;
        if (load_i) begin
            pend_value_d = value_i;
            pend_dp_d    = dp_i;
            pend_lz_d    = blank_lz_i;
            pend_valid_d = 1'b1;
        end
        if (commit && pend_valid_d) begin
            act_value_d  = pend_value_d;
            act_dp_d     = pend_dp_d;
            act_lz_d     = pend_lz_d;
            pend_valid_d = 1'b0;
        end
    end

    // Digit i is blanked when every nibble from i upward is zero
    always_comb begin
        logic zeros_above;
        zeros_above = 1'b1;
        lz_blank    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zeros_above = zeros_above && (act_value_q[4*i +: 4] == 4'h0);
            lz_blank[i] = act_lz_q && zeros_above && (i != 0);
        end
    end

    always_comb begin
        cur_nibble = '0;
        cur_blank  = 1'b0;
        cur_dp     = 1'b0;
        onehot     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IdxW'(i)) begin
                cur_nibble = act_value_q[4*i +: 4];
                cur_blank  = lz_blank[i];
                cur_dp     = act_dp_q[i];
                onehot[i]  = 1'b1;
            end
        end
    end

    ssdec_font u_font (
        .nibble_i (cur_nibble),
        .blank_i  (cur_blank),
        .seg_o    (font_seg)
    );

    // Polarity is applied here so the pads are driven straight from flops
    always_comb begin
        seg_d        = {7{ACTIVE_LOW}};
        dp_d         = ACTIVE_LOW;
        sel_d        = {NUM_DIGITS{ACTIVE_LOW}};
        frame_done_d = 1'b0;
        if (state_q == SCAN && enable_i) begin
            seg_d        = font_seg ^ {7{ACTIVE_LOW}};
            dp_d         = cur_dp ^ ACTIVE_LOW;
            frame_done_d = wrap_q;
            if (presc_q >= BlankEnd) begin
                sel_d = onehot ^ {NUM_DIGITS{ACTIVE_LOW}};
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            presc_q      <= '0;
            idx_q        <= '0;
            wrap_q       <= 1'b0;
            pend_value_q <= '0;
            pend_dp_q    <= '0;
            pend_lz_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            act_value_q  <= '0;
            act_dp_q     <= '0;
            act_lz_q     <= 1'b0;
            seg_q        <= {7{ACTIVE_LOW}};
            dp_q         <= ACTIVE_LOW;
            sel_q        <= {NUM_DIGITS{ACTIVE_LOW}};
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            wrap_q       <= wrap_d;
            pend_value_q <= pend_value_d;
            pend_dp_q    <= pend_dp_d;
            pend_lz_q    <= pend_lz_d;
            pend_valid_q <= pend_valid_d;
            act_value_q  <= act_value_d;
            act_dp_q     <= act_dp_d;
            act_lz_q     <= act_lz_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            sel_q        <= sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_out_o    = seg_q;
    assign dp_out_o     = dp_q;
    assign digit_sel_o  = sel_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_ssdec_scan.sv
// Scoreboard bench: a frame-level reference model queues expected pad values per cycle,
// a negedge monitor compares both an active-high and an active-low instance.
module tb_ssdec_scan;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int BC = 1;

    typedef struct packed {
        logic [6:0]    seg;
        logic          dp;
        logic [ND-1:0] sel;
        logic          fd;
    } out_t;

    logic            clk, rst, enable, load, blank_lz;
    logic [4*ND-1:0] value;
    logic [ND-1:0]   dp;
    logic [6:0]      seg_h, seg_l;
    logic            dp_h, dp_l, fd_h, fd_l;
    logic [ND-1:0]   sel_h, sel_l;

    int checks   = 0;
    int failures = 0;

    out_t exp_q[$];

    logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    ssdec_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC), .ACTIVE_LOW(1'b0)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .load_i(load), .value_i(value),
        .dp_i(dp), .blank_lz_i(blank_lz), .seg_out_o(seg_h), .dp_out_o(dp_h),
        .digit_sel_o(sel_h), .frame_done_o(fd_h)
    );

    ssdec_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC), .ACTIVE_LOW(1'b1)) dut_al (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .load_i(load), .value_i(value),
        .dp_i(dp), .blank_lz_i(blank_lz), .seg_out_o(seg_l), .dp_out_o(dp_l),
        .digit_sel_o(sel_l), .frame_done_o(fd_l)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: time since scan start, frames of SD*ND cycles, buffered commits
    bit              m_scan;
    int              m_t;
    logic [4*ND-1:0] p_val, a_val;
    logic [ND-1:0]   p_dp, a_dp;
    bit              p_lz, a_lz, p_valid;

    always @(posedge clk) begin
        out_t e;
        int   dig, ph;
        bit   blank, commit;
        e = '0;
        if (rst) begin
            m_scan = 0; m_t = 0; p_valid = 0;
            p_val = '0; p_dp = '0; p_lz = 0;
            a_val = '0; a_dp = '0; a_lz = 0;
        end else begin
            if (m_scan && enable) begin
                dig   = (m_t / SD) % ND;
                ph    = m_t % SD;
                blank = (dig > 0) && a_lz && ((a_val >> (4 * dig)) == 0);
                e.seg = blank ? 7'h00 : font[a_val[4*dig +: 4]];
                e.dp  = a_dp[dig];
                e.sel = (ph >= BC) ? ND'(1 << dig) : '0;
                e.fd  = (m_t > 0) && (m_t % (SD * ND) == 0);
            end
            if (load) begin
                p_val = value; p_dp = dp; p_lz = blank_lz; p_valid = 1;
            end
            commit = 0;
            if (!m_scan) begin
                if (enable) begin
                    m_scan = 1; m_t = 0; commit = 1;
                end
            end else if (!enable) begin
                m_scan = 0;
            end else begin
                m_t++;
                commit = (m_t % (SD * ND) == 0);
            end
            if (commit && p_valid) begin
                a_val = p_val; a_dp = p_dp; a_lz = p_lz; p_valid = 0;
            end
        end
        exp_q.push_back(e);
    end

    // Monitor: pop one expectation per cycle, compare both polarities
    always @(negedge clk) begin
        out_t e, e_l, got_h, got_l;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rst) e = '0;
            e_l   = '{seg: ~e.seg, dp: ~e.dp, sel: ~e.sel, fd: e.fd};
            got_h = '{seg: seg_h, dp: dp_h, sel: sel_h, fd: fd_h};
            got_l = '{seg: seg_l, dp: dp_l, sel: sel_l, fd: fd_l};
            checks++;
            if (got_h !== e) begin
                failures++;
                $display("FAIL scan_hi t=%0t got seg=%h dp=%b sel=%b fd=%b exp seg=%h dp=%b sel=%b fd=%b",
                         $time, got_h.seg, got_h.dp, got_h.sel, got_h.fd,
                         e.seg, e.dp, e.sel, e.fd);
            end
            checks++;
            if (got_l !== e_l) begin
                failures++;
                $display("FAIL scan_lo t=%0t got seg=%h dp=%b sel=%b fd=%b exp seg=%h dp=%b sel=%b fd=%b",
                         $time, got_l.seg, got_l.dp, got_l.sel, got_l.fd,
                         e_l.seg, e_l.dp, e_l.sel, e_l.fd);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_load(input logic [4*ND-1:0] v, input logic [ND-1:0] d, input logic lz);
        value = v; dp = d; blank_lz = lz; load = 1'b1;
        @(posedge clk);
        #2;
        load = 1'b0;
    endtask

    task automatic check_inactive(input string tag);
        check({tag, "_seg_hi"}, 32'(seg_h), 32'h00);
        check({tag, "_sel_hi"}, 32'(sel_h), 32'h0);
        check({tag, "_dp_hi"},  32'(dp_h),  32'h0);
        check({tag, "_fd_hi"},  32'(fd_h),  32'h0);
        check({tag, "_seg_lo"}, 32'(seg_l), 32'h7F);
        check({tag, "_sel_lo"}, 32'(sel_l), 32'hF);
        check({tag, "_dp_lo"},  32'(dp_l),  32'h1);
        check({tag, "_fd_lo"},  32'(fd_l),  32'h0);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; load = 1'b0;
        value = '0; dp = '0; blank_lz = 1'b0;
        idle(3);
        check_inactive("reset");
        rst = 1'b0;
        idle(2);

        // Enable and load together: commits on the IDLE->SCAN transition
        enable = 1'b1;
        do_load(16'h12AF, 4'b0000, 1'b0);
        idle(40);

        do_load(16'h0042, 4'b0010, 1'b1);
        idle(36);

        // Load mid-frame: current frame keeps the old value
        idle(5);
        do_load(16'h8888, 4'b0000, 1'b0);
        idle(40);

        // Disable partway through a frame, load while idle, re-enable
        idle(9);
        enable = 1'b0;
        idle(4);
        do_load(16'h0000, 4'b1001, 1'b0);
        idle(3);
        enable = 1'b1;
        idle(30);

        // Reset mid-frame with a load still pending
        idle(13);
        do_load(16'hBEEF, 4'b1111, 1'b0);
        idle(2);
        rst = 1'b1;
        #1;
        check_inactive("midrst");
        idle(2);
        rst = 1'b0;
        idle(24);

        // Randomized traffic, biased toward leading zeros and sustained scanning
        for (int i = 0; i < 900; i++) begin
            logic [4*ND-1:0] v;
            v = 16'($urandom);
            case ($urandom_range(0, 3))
                0: v = v & 16'h000F;
                1: v = v & 16'h00FF;
                2: v = v & 16'h0FFF;
                default: ;
            endcase
            value    = v;
            dp       = 4'($urandom);
            blank_lz = 1'($urandom);
            load     = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 59) == 0) enable = ~enable;
            if ($urandom_range(0, 399) == 0) rst = 1'b1;
            else rst = 1'b0;
            @(posedge clk);
            #2;
        end
        rst = 1'b0; load = 1'b0; enable = 1'b1;
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
